// File: rtl/i2s_rx_if.sv
// i2s_rx_if: bundle of the I2S receive pins and the recovered PCM outputs.
//   sclk, lr_clk, sdat      I2S bit clock, word select, serial data (driven by the bus master)
//   left_out, right_out     last complete stereo pair, two's complement
//   out_tick                one-cycle pulse when left_out/right_out change
//   frame_err               sticky slot-length error flag
// Modports: master = stream source / consumer side, slave = the receiver.
interface i2s_rx_if #(
  parameter int SAMPLE_BITS = 16
);
  logic                   sclk;
  logic                   lr_clk;
  logic                   sdat;
  logic [SAMPLE_BITS-1:0] left_out;
  logic [SAMPLE_BITS-1:0] right_out;
  logic                   out_tick;
  logic                   frame_err;

  modport master (
    output sclk, lr_clk, sdat,
    input  left_out, right_out, out_tick, frame_err
  );

  modport slave (
    input  sclk, lr_clk, sdat,
    output left_out, right_out, out_tick, frame_err
  );
endinterface

// File: rtl/i2s_rx.sv
// i2s_rx: I2S slave receiver. Oversamples an external I2S stream in the CLK
// domain and delivers left/right PCM pairs with a one-cycle out_tick.
// Ports:
//   CLK   system clock, all logic on the rising edge
//   RST   asynchronous active-high reset
//   bus   i2s_rx_if.slave (sclk, lr_clk, sdat in; left_out, right_out,
//         out_tick, frame_err out)
// Optional feature: define I2S_RX_FRAME_CHECK_EN to compare every slot length
// against SLOT_BITS and raise a sticky frame_err; otherwise frame_err is 0.
//
// state | meaning
// HUNT  | waiting for the first lr change seen at an sclk rise
// RUN   | aligned to slots, shifting bits and finalizing words at lr edges
module i2s_rx #(
  parameter int SAMPLE_BITS = 16,
  parameter int SLOT_BITS   = 32
) (
  input logic     CLK,
  input logic     RST,
  i2s_rx_if.slave bus
);
  localparam logic [0:0] HUNT = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  logic sclk_s1, sclk_s2, sclk_s3;
  logic lr_s1, lr_s2;
  logic sdat_s1, sdat_s2;
  logic rise_q, lr_q, sdat_q;

  logic [0:0]             state;
  logic                   lr_prev;
  logic [5:0]             bit_cnt;
  logic [SAMPLE_BITS-1:0] shreg;
  logic [SAMPLE_BITS-1:0] word;
  logic [SAMPLE_BITS-1:0] staging_left;
  logic                   have_left;
  logic [SAMPLE_BITS-1:0] left_q, right_q;
  logic                   tick_q;
  logic                   lr_edge;
  logic                   slot_ok;

  // Synchronizers plus a registered rise strobe; lr/sdat are captured from
  // their s2 stage alongside the rise so the FSM sees one coherent sample.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sclk_s1 <= 1'b0;
      sclk_s2 <= 1'b0;
      sclk_s3 <= 1'b0;
      lr_s1   <= 1'b0;
      lr_s2   <= 1'b0;
      sdat_s1 <= 1'b0;
      sdat_s2 <= 1'b0;
      rise_q  <= 1'b0;
      lr_q    <= 1'b0;
      sdat_q  <= 1'b0;
    end else begin
      sclk_s1 <= bus.sclk;
      sclk_s2 <= sclk_s1;
      sclk_s3 <= sclk_s2;
      lr_s1   <= bus.lr_clk;
      lr_s2   <= lr_s1;
      sdat_s1 <= bus.sdat;
      sdat_s2 <= sdat_s1;
      rise_q  <= sclk_s2 & ~sclk_s3;
      lr_q    <= lr_s2;
      sdat_q  <= sdat_s2;
    end
  end

  // Current word with this rise's bit inserted MSB-first; bits beyond
  // SAMPLE_BITS match no position and are dropped.
  always_comb begin
    word = shreg;
    for (int i = 0; i < SAMPLE_BITS; i++) begin
      if (i == SAMPLE_BITS - 1 - int'(bit_cnt)) word[i] = sdat_q;
    end
  end

  assign lr_edge = (lr_q != lr_prev);

`ifdef I2S_RX_FRAME_CHECK_EN
  logic first_slot;
  logic frame_err_q;

  // Slot length counts the edge bit as well; the slot that was already in
  // progress when HUNT locked on is of unknown length and is not judged.
  assign slot_ok = first_slot || (({1'b0, bit_cnt} + 7'd1) == 7'(SLOT_BITS));

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      first_slot  <= 1'b0;
      frame_err_q <= 1'b0;
    end else if (rise_q && lr_edge) begin
      if (state == HUNT) begin
        first_slot <= 1'b1;
      end else begin
        first_slot <= 1'b0;
        if (!slot_ok) frame_err_q <= 1'b1;
      end
    end
  end

  assign bus.frame_err = frame_err_q;
`else
  assign slot_ok       = 1'b1;
  assign bus.frame_err = 1'b0;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= HUNT;
      lr_prev      <= 1'b0;
      bit_cnt      <= 6'd0;
      shreg        <= '0;
      staging_left <= '0;
      have_left    <= 1'b0;
      left_q       <= '0;
      right_q      <= '0;
      tick_q       <= 1'b0;
    end else begin
      tick_q <= 1'b0;
      if (rise_q) begin
        lr_prev <= lr_q;
        if (state == HUNT) begin
          if (lr_edge) state <= RUN;
        end else if (!lr_edge) begin
          shreg <= word;
          if (bit_cnt != 6'd63) bit_cnt <= bit_cnt + 6'd1;
        end else begin
          // The edge bit closes the slot; the next rise carries the new MSB.
          shreg   <= '0;
          bit_cnt <= 6'd0;
          if (!slot_ok) begin
            have_left <= 1'b0;
          end else if (!lr_prev) begin
            staging_left <= word;
            have_left    <= 1'b1;
          end else if (have_left) begin
            left_q    <= staging_left;
            right_q   <= word;
            tick_q    <= 1'b1;
            have_left <= 1'b0;
          end
        end
      end
    end
  end

  assign bus.left_out  = left_q;
  assign bus.right_out = right_q;
  assign bus.out_tick  = tick_q;
endmodule

// File: tb/tb_i2s_rx.sv
// tb_i2s_rx: self-checking bench for i2s_rx. Drives I2S frames bit by bit,
// pushes the expected pair per frame into a scoreboard queue, and a monitor
// pops and compares on every out_tick (values, width, latency, hold).
module tb_i2s_rx;
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  i2s_rx_if #(.SAMPLE_BITS(16)) bus ();

  i2s_rx #(.SAMPLE_BITS(16), .SLOT_BITS(32)) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    logic [15:0] l;
    logic [15:0] r;
  } pair_t;

  typedef struct {
    logic [31:0] lv;
    logic [31:0] rv;
    int          n;
    logic [15:0] el;
    logic [15:0] er;
  } vec_t;

  pair_t       q[$];
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          ticks = 0;
  int          edge_cyc = 0;
  int          half = 16;
  int          t0;
  logic        carry = 1'b0;
  logic        cur_lr = 1'b0;
  logic        prev_tick = 1'b0;
  logic [15:0] hold_l = '0;
  logic [15:0] hold_r = '0;
  vec_t        vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One sclk period: lr/sdat change with the falling edge, sampled on the rise.
  task automatic drive_bit(input logic lr, input logic d);
    @(negedge CLK);
    bus.sclk   = 1'b0;
    bus.lr_clk = lr;
    bus.sdat   = d;
    repeat (half) @(negedge CLK);
    bus.sclk = 1'b1;
    if (cur_lr && !lr) edge_cyc = cyc;
    cur_lr = lr;
    repeat (half - 1) @(negedge CLK);
  endtask

  // n rises with word select lr; the first rise carries the previous slot's
  // last bit, then v is sent MSB-first (its LSB goes out on the next edge).
  task automatic send_slot(input logic lr, input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) drive_bit(lr, (i == 0) ? carry : v[n-i]);
    carry = v[0];
  endtask

  task automatic send_frame(input logic [31:0] lv, input logic [31:0] rv, input int n);
    send_slot(1'b0, lv, n);
    send_slot(1'b1, rv, n);
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    pair_t p;
    p.l = l;
    p.r = r;
    q.push_back(p);
  endtask

  task automatic flush();
    drive_bit(1'b0, carry);
    carry = 1'b0;
    repeat (20) @(negedge CLK);
    check("drain", q.size(), 0);
    q.delete();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b1;
    repeat (2) @(negedge CLK);
    RST    = 1'b0;
    carry  = 1'b0;
    cur_lr = 1'b0;
    q.delete();
  endtask

  always @(posedge CLK) begin
    pair_t p;
    cyc++;
    #1;
    if (RST) begin
      hold_l    = '0;
      hold_r    = '0;
      prev_tick = 1'b0;
    end else begin
      if (bus.out_tick) begin
        ticks++;
        check("tick_width", prev_tick, 1'b0);
        check("tick_latency", cyc - edge_cyc, 4);
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_tick: got L=%h R=%h expected no tick", bus.left_out, bus.right_out);
        end else begin
          p = q.pop_front();
          check("left_out", bus.left_out, p.l);
          check("right_out", bus.right_out, p.r);
          hold_l = p.l;
          hold_r = p.r;
        end
      end else begin
        check("hold_left", bus.left_out, hold_l);
        check("hold_right", bus.right_out, hold_r);
      end
      prev_tick = bus.out_tick;
    end
  end

  initial begin
    vecs = '{
      '{32'h1234_0000, 32'hABCD_0000, 32, 16'h1234, 16'hABCD},
      '{32'h1234_0000, 32'hABCD_0000, 32, 16'h1234, 16'hABCD},
      '{32'h1234_0000, 32'hABCD_0000, 32, 16'h1234, 16'hABCD},
      '{32'h0000_00A5, 32'h0000_005A,  8, 16'hA500, 16'h5A00},
      '{32'h00DE_ADBE, 32'h0000_01FF, 24, 16'hDEAD, 16'h0001},
      '{32'h000F_FFFF, 32'h0001_2345, 20, 16'hFFFF, 16'h1234},
      '{32'h0000_0002, 32'h0000_0001,  2, 16'h8000, 16'h4000},
      '{32'h0001_0001, 32'h0000_FFFF, 17, 16'h8000, 16'h7FFF}
    };
    bus.sclk   = 1'b0;
    bus.lr_clk = 1'b0;
    bus.sdat   = 1'b0;

    repeat (3) @(negedge CLK);
    check("rst_left", bus.left_out, 16'h0000);
    check("rst_right", bus.right_out, 16'h0000);
    check("rst_tick", bus.out_tick, 1'b0);
    check("rst_err", bus.frame_err, 1'b0);
    RST = 1'b0;

    // Table: warm-up frame locks HUNT->RUN, then every vector yields one pair.
    half = 16;
    t0 = ticks;
    send_frame(32'h0, 32'h0, 32);
    for (int k = 0; k < 8; k++) begin
`ifdef I2S_RX_FRAME_CHECK_EN
      if (vecs[k].n != 32) continue;
`endif
      push(vecs[k].el, vecs[k].er);
      send_frame(vecs[k].lv, vecs[k].rv, vecs[k].n);
    end
    flush();
`ifdef I2S_RX_FRAME_CHECK_EN
    check("table_ticks", ticks - t0, 3);
`else
    check("table_ticks", ticks - t0, 8);
`endif
    check("table_err", bus.frame_err, 1'b0);

    // Stream starting mid-right-slot: partial right word must be discarded.
    half = 4;
    do_reset();
    t0 = ticks;
    send_slot(1'b1, 32'hFFFF_FFFF, 10);
    push(16'h5555, 16'h3C3C);
    send_frame(32'h5555_0000, 32'h3C3C_0000, 32);
    push(16'hC001, 16'h0FF0);
    send_frame(32'hC001_0000, 32'h0FF0_0000, 32);
    flush();
    check("midright_ticks", ticks - t0, 2);

    // Reset mid-left-slot: outputs clear at once, re-lock before next tick.
    do_reset();
    send_frame(32'h0, 32'h0, 32);
    push(16'h2468, 16'h1357);
    send_frame(32'h2468_0000, 32'h1357_0000, 32);
    send_slot(1'b0, 32'h9999_0000, 12);
    repeat (10) @(negedge CLK);
    check("pre_reset_drain", q.size(), 0);
    RST = 1'b1;
    #1;
    check("mid_rst_left", bus.left_out, 16'h0000);
    check("mid_rst_right", bus.right_out, 16'h0000);
    check("mid_rst_tick", bus.out_tick, 1'b0);
    check("mid_rst_err", bus.frame_err, 1'b0);
    repeat (2) @(negedge CLK);
    RST = 1'b0;
    t0 = ticks;
    for (int i = 0; i < 20; i++) drive_bit(1'b0, 1'b1);
    carry = 1'b1;
    send_slot(1'b1, 32'hFFFF_FFFF, 32);
    push(16'h0F0F, 16'hF0F0);
    send_frame(32'h0F0F_0000, 32'hF0F0_0000, 32);
    flush();
    check("post_reset_ticks", ticks - t0, 1);

    // 100 back-to-back frames at the fastest supported sclk.
    half = 3;
    do_reset();
    send_frame(32'h0, 32'h0, 32);
    t0 = ticks;
    for (int k = 0; k < 100; k++) begin
      push(16'h8000, 16'h7FFF);
      send_frame(32'h8000_0000, 32'h7FFF_0000, 32);
    end
    flush();
    check("burst_ticks", ticks - t0, 100);
    check("burst_err", bus.frame_err, 1'b0);

`ifdef I2S_RX_FRAME_CHECK_EN
    // One 31-bit left slot: sticky error, that pair suppressed, later pairs tick.
    half = 4;
    do_reset();
    send_frame(32'h0, 32'h0, 32);
    t0 = ticks;
    push(16'h1111, 16'h2222);
    send_frame(32'h1111_0000, 32'h2222_0000, 32);
    send_slot(1'b0, 32'h0888_8000, 31);
    send_slot(1'b1, 32'h4444_0000, 32);
    check("err_set", bus.frame_err, 1'b1);
    push(16'h5555, 16'h6666);
    send_frame(32'h5555_0000, 32'h6666_0000, 32);
    push(16'h7777, 16'h1357);
    send_frame(32'h7777_0000, 32'h1357_0000, 32);
    flush();
    check("err_ticks", ticks - t0, 3);
    check("err_sticky", bus.frame_err, 1'b1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
